pic_inta_sequencer: RTL and testbench

//  Downstream of priority_resolver: consumes its INT request and winning IR level, runs the

---
 rtl/pic_pkg.sv | 23 ++
 rtl/pic_sync_edge.sv | 31 +++
 rtl/pic_inta_sequencer.sv | 139 +++++++++++++
 tb/tb_pic_inta_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the 8259A-style interrupt acknowledge logic.
package pic_pkg;

    localparam int          LVL_W        = 3;
    localparam logic [7:0]  CALL_OPCODE  = 8'hCD;
    localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

    // Acknowledge sequencer states: ACKn is an INTA low pulse, GAPn the high time after it.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACK1 = 3'd1,
        ST_GAP1 = 3'd2,
        ST_ACK2 = 3'd3,
        ST_GAP2 = 3'd4,
        ST_ACK3 = 3'd5
    } inta_state_t;

    // One-hot decode of an IR level onto the 8 ISR/IRR bit positions.
    function automatic logic [7:0] lvl_onehot(input logic [LVL_W-1:0] lvl);
        lvl_onehot = 8'h01 << lvl;
    endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// Multi-flop synchronizer for the raw INTA pin with fall/rise pulse detection.
module pic_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_sync,
    output logic o_fall,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the pin through the chain; idle level of an active-low pin is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_fall = r_prev & ~r_sync[SYNC_STAGES-1];
    assign o_rise = ~r_prev & r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pic_inta_sequencer.sv
// INTA bus-cycle sequencer: drives vector/CALL bytes and ISR/freeze/AEOI strobes.
module pic_inta_sequencer
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inta_n,
    input  logic       int_req,
    input  logic [2:0] int_level,
    input  logic       mode_8086,
    input  logic       aeoi,
    input  logic       adi,
    input  logic [4:0] vec_base,
    input  logic [2:0] addr_low,
    input  logic [7:0] addr_high,
    input  logic       init_abort,
    output logic [7:0] dout,
    output logic       dout_oe,
    output logic [7:0] isr_set,
    output logic       freeze,
    output logic [7:0] eoi_clr
);

    inta_state_t      r_state;
    inta_state_t      w_next;
    logic [LVL_W-1:0] r_lvl;
    logic             r_spur;
    logic             r_mode;
    logic [7:0]       r_dout;
    logic [7:0]       r_isr_set;
    logic [7:0]       r_eoi_clr;

    logic             w_sync;
    logic             w_fall;
    logic             w_rise;
    logic             w_start;
    logic             w_finish;
    logic             w_load;
    logic [7:0]       w_byte;

    pic_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_din  (inta_n),
        .o_sync (w_sync),
        .o_fall (w_fall),
        .o_rise (w_rise)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus start/finish/byte-load strobes; init_abort overrides every edge.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_finish = 1'b0;
        w_load   = 1'b0;
        w_byte   = r_dout;
        if (init_abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_fall) begin
                    w_next  = ST_ACK1;
                    w_start = 1'b1;
                    w_load  = !mode_8086;
                    w_byte  = CALL_OPCODE;
                end
                ST_ACK1: if (w_rise) w_next = ST_GAP1;
                ST_GAP1: if (w_fall) begin
                    w_next = ST_ACK2;
                    w_load = 1'b1;
                    if (r_mode)
                        w_byte = {vec_base, r_lvl};
                    else if (adi)
                        w_byte = {addr_low, r_lvl, 2'b00};
                    else
                        w_byte = {addr_low[2:1], r_lvl, 3'b000};
                end
                ST_ACK2: if (w_rise) begin
                    w_next   = r_mode ? ST_IDLE : ST_GAP2;
                    w_finish = r_mode;
                end
                ST_GAP2: if (w_fall) begin
                    w_next = ST_ACK3;
                    w_load = 1'b1;
                    w_byte = addr_high;
                end
                ST_ACK3: if (w_rise) begin
                    w_next   = ST_IDLE;
                    w_finish = 1'b1;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Sequence context (level, spurious flag, mode), the held data byte and the strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl     <= '0;
            r_spur    <= 1'b0;
            r_mode    <= 1'b0;
            r_dout    <= 8'h00;
            r_isr_set <= 8'h00;
            r_eoi_clr <= 8'h00;
        end else begin
            if (w_start) begin
                r_lvl  <= int_req ? int_level : SPURIOUS_LVL;
                r_spur <= !int_req;
                r_mode <= mode_8086;
            end
            if (w_load) begin
                r_dout <= w_byte;
            end
            r_isr_set <= (w_start && int_req) ? lvl_onehot(int_level) : 8'h00;
            r_eoi_clr <= (w_finish && aeoi && !r_spur) ? lvl_onehot(r_lvl) : 8'h00;
        end
    end

    assign dout    = r_dout;
    assign dout_oe = ((r_state == ST_ACK1) && !r_mode) ||
                     (r_state == ST_ACK2) || (r_state == ST_ACK3);
    assign freeze  = (r_state != ST_IDLE);
    assign isr_set = r_isr_set;
    assign eoi_clr = r_eoi_clr;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: vector table plus hand-written corner sequences.
module tb_pic_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inta_n = 1'b1;
    logic       int_req = 1'b0;
    logic [2:0] int_level = 3'd0;
    logic       mode_8086 = 1'b1;
    logic       aeoi = 1'b0;
    logic       adi = 1'b0;
    logic [4:0] vec_base = 5'd0;
    logic [2:0] addr_low = 3'd0;
    logic [7:0] addr_high = 8'd0;
    logic       init_abort = 1'b0;
    logic [7:0] dout;
    logic       dout_oe;
    logic [7:0] isr_set;
    logic       freeze;
    logic [7:0] eoi_clr;

    int n_checks = 0;
    int n_errors = 0;

    pic_inta_sequencer #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inta_n     (inta_n),
        .int_req    (int_req),
        .int_level  (int_level),
        .mode_8086  (mode_8086),
        .aeoi       (aeoi),
        .adi        (adi),
        .vec_base   (vec_base),
        .addr_low   (addr_low),
        .addr_high  (addr_high),
        .init_abort (init_abort),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .isr_set    (isr_set),
        .freeze     (freeze),
        .eoi_clr    (eoi_clr)
    );

    always #5 clk = ~clk;

    // Monitor: records each data byte (first cycle of dout_oe) and every strobe.
    logic       mon_rst = 1'b0;
    logic [7:0] bytes [0:3];
    int         nbytes = 0;
    int         isr_cnt = 0;
    int         eoi_cnt = 0;
    logic [7:0] isr_val = 8'h00;
    logic [7:0] eoi_val = 8'h00;
    logic       prev_oe = 1'b0;

    always @(negedge clk) begin
        if (mon_rst) begin
            nbytes  = 0;
            isr_cnt = 0;
            eoi_cnt = 0;
            isr_val = 8'h00;
            eoi_val = 8'h00;
        end else begin
            if (isr_set != 8'h00) begin
                isr_cnt = isr_cnt + 1;
                isr_val = isr_val | isr_set;
            end
            if (eoi_clr != 8'h00) begin
                eoi_cnt = eoi_cnt + 1;
                eoi_val = eoi_val | eoi_clr;
            end
            if (dout_oe && !prev_oe && nbytes < 4) begin
                bytes[nbytes] = dout;
                nbytes = nbytes + 1;
            end
        end
        prev_oe = dout_oe;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        @(posedge clk);
        mon_rst = 1'b1;
        @(negedge clk);
        #1 mon_rst = 1'b0;
    endtask

    // One INTA pulse: 4 clocks low, 4 clocks high (longer than the sync latency).
    task automatic inta_pulse();
        @(posedge clk);
        #1 inta_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 inta_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    typedef struct {
        logic       m86;
        logic       aeoi;
        logic       adi;
        logic       req;
        logic [4:0] vb;
        logic [2:0] al;
        logic [7:0] ah;
        logic [2:0] lvl;
        int         nb;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] isr;
        logic [7:0] eoi;
    } vec_t;

    vec_t vecs [0:5];

    task automatic set_cfg(input vec_t v);
        mode_8086 = v.m86;
        aeoi      = v.aeoi;
        adi       = v.adi;
        int_req   = v.req;
        vec_base  = v.vb;
        addr_low  = v.al;
        addr_high = v.ah;
        int_level = v.lvl;
    endtask

    initial begin
        //          m86  aeoi adi  req  vb     al      ah     lvl  nb b0     b1     b2     isr    eoi
        vecs[0] = '{1'b1,1'b0,1'b0,1'b1,5'h08,3'b000,8'h00,3'd3,1,8'h43,8'h00,8'h00,8'h08,8'h00};
        vecs[1] = '{1'b0,1'b0,1'b1,1'b1,5'h00,3'b101,8'h12,3'd5,3,8'hCD,8'hB4,8'h12,8'h20,8'h00};
        vecs[2] = '{1'b0,1'b0,1'b0,1'b1,5'h00,3'b101,8'h34,3'd2,3,8'hCD,8'h90,8'h34,8'h04,8'h00};
        vecs[3] = '{1'b1,1'b1,1'b0,1'b0,5'h1F,3'b000,8'h00,3'd2,1,8'hFF,8'h00,8'h00,8'h00,8'h00};
        vecs[4] = '{1'b1,1'b1,1'b0,1'b1,5'h08,3'b000,8'h00,3'd6,1,8'h46,8'h00,8'h00,8'h40,8'h40};
        vecs[5] = '{1'b0,1'b1,1'b1,1'b1,5'h00,3'b000,8'hFF,3'd0,3,8'hCD,8'h00,8'hFF,8'h01,8'h01};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_dout", dout, 8'h00);
        chk("reset_oe", dout_oe, 0);
        chk("reset_isr", isr_set, 8'h00);
        chk("reset_freeze", freeze, 0);
        chk("reset_eoi", eoi_clr, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven full sequences.
        for (int i = 0; i < 6; i++) begin
            set_cfg(vecs[i]);
            clr_mon();
            inta_pulse();
            @(negedge clk);
            chk($sformatf("v%0d_freeze_gap1", i), freeze, 1);
            for (int p = 1; p < (vecs[i].m86 ? 2 : 3); p++) inta_pulse();
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_nbytes", i), nbytes, vecs[i].nb);
            if (nbytes > 0) chk($sformatf("v%0d_b0", i), bytes[0], vecs[i].b0);
            if (vecs[i].nb > 1 && nbytes > 2) begin
                chk($sformatf("v%0d_b1", i), bytes[1], vecs[i].b1);
                chk($sformatf("v%0d_b2", i), bytes[2], vecs[i].b2);
            end
            chk($sformatf("v%0d_isr_cnt", i), isr_cnt, vecs[i].req ? 1 : 0);
            chk($sformatf("v%0d_isr", i), isr_val, vecs[i].isr);
            chk($sformatf("v%0d_eoi_cnt", i), eoi_cnt, (vecs[i].eoi != 8'h00) ? 1 : 0);
            chk($sformatf("v%0d_eoi", i), eoi_val, vecs[i].eoi);
            chk($sformatf("v%0d_freeze_end", i), freeze, 0);
            chk($sformatf("v%0d_oe_end", i), dout_oe, 0);
            $display("vec %0d: mode86=%0b lvl=%0d bytes=%0d isr=%02h eoi=%02h",
                     i, vecs[i].m86, vecs[i].lvl, nbytes, isr_val, eoi_val);
        end

        // Latency: raw fall to dout_oe rise in 8080 mode is SYNC_STAGES+1 clocks.
        begin
            int lat;
            set_cfg(vecs[1]);
            @(posedge clk);
            #1 inta_n = 1'b0;
            lat = 0;
            while (!dout_oe && lat < 20) begin
                @(posedge clk);
                lat = lat + 1;
                #1;
            end
            chk("latency_fall_to_oe", lat, 3);
            repeat (2) @(posedge clk);
            #1 init_abort = 1'b1;
            @(posedge clk);
            #1 init_abort = 1'b0;
            inta_n = 1'b1;
            repeat (6) @(posedge clk);
            $display("latency: %0d clocks", lat);
        end

        // init_abort during GAP1, then a fresh sequence.
        set_cfg(vecs[0]);
        inta_pulse();
        #1 init_abort = 1'b1;
        @(posedge clk);
        #1 init_abort = 1'b0;
        @(negedge clk);
        chk("abort_oe", dout_oe, 0);
        chk("abort_freeze", freeze, 0);
        clr_mon();
        inta_pulse();
        inta_pulse();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_after_nbytes", nbytes, 1);
        if (nbytes > 0) chk("abort_after_byte", bytes[0], 8'h43);
        chk("abort_after_isr_cnt", isr_cnt, 1);
        chk("abort_after_freeze", freeze, 0);
        $display("abort seq: bytes=%0d isr_cnt=%0d", nbytes, isr_cnt);

        // rst_n low during GAP1 with AEOI on: no eoi_clr, then a fresh sequence.
        set_cfg(vecs[4]);
        clr_mon();
        inta_pulse();
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_oe", dout_oe, 0);
        chk("rst_freeze", freeze, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        chk("rst_no_eoi", eoi_cnt, 0);
        clr_mon();
        inta_pulse();
        inta_pulse();
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (nbytes > 0) chk("rst_after_byte", bytes[0], 8'h46);
        chk("rst_after_eoi", eoi_val, 8'h40);
        $display("reset seq: bytes=%0d eoi=%02h", nbytes, eoi_val);

        // Mode change mid-sequence does not alter the pulse count.
        set_cfg(vecs[0]);
        int_level = 3'd1;
        clr_mon();
        inta_pulse();
        mode_8086 = 1'b0;
        inta_pulse();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("modechg_freeze", freeze, 0);
        chk("modechg_nbytes", nbytes, 1);
        if (nbytes > 0) chk("modechg_byte", bytes[0], 8'h41);
        $display("mode change seq: bytes=%0d freeze=%0b", nbytes, freeze);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
